tt_sel_seq: RTL and testbench
=============================

Name: tt_sel_seq

Overview:
- Sequencer that drives the three control-high select pins (sel_rst_n, sel_inc, ena) of the multiplexer controller.
- Converts a requested design address into the required pulse train: an optional select-chain reset, N increment pulses, then an enable update.
- Lives in the test/management side of the chip, one instance per TT mux tree.
- Tracks the currently selected address. When the target is at or above the current address, it skips the chain reset and pulses only the difference.

Parameters:
- ADDR_W, 10, width of the design address (mux address plus block index, counted linearly by the inc chain).
- PHASE, 2, cycles each pin phase is held (≥1). Every low or high half-phase lasts exactly PHASE clk cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request strobe.
- req_ready  output  1  block idle; a request is accepted on any clk edge where req_valid & req_ready.
- req_addr  input  ADDR_W  target address, captured on accept.
- req_ena  input  1  value of ctrl_ena to apply after selection, captured on accept.
- sel_valid  output  1  cur_addr reflects the real chain state.
- cur_addr  output  ADDR_W  currently selected address.
- ctrl_sel_rst_n  output  1  to pad_ch_in[4] (active-low chain reset).
- ctrl_sel_inc  output  1  to pad_ch_in[2] (increment, rising edge counts).
- ctrl_ena  output  1  to pad_ch_in[0].

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs except req_ready, which is a pure state decode.
- Reset values (applied asynchronously, immediately on rst high):
  - ctrl_sel_rst_n = 1, ctrl_sel_inc = 0, ctrl_ena = 0.
  - sel_valid = 0, cur_addr = 0.
  - State IDLE, so req_ready = 1 once rst is low.
- States: IDLE, RST_LO, RST_HI, INC_HI, INC_LO. One phase counter (width clog2(PHASE)+1) and one remaining-increment counter (ADDR_W).
- Accept in IDLE, with T = req_addr:
  - Same-address case (sel_valid & T == cur_addr): ctrl_ena <= req_ena on the same edge. State stays IDLE, req_ready stays 1, no pin pulses.
  - Incremental case (sel_valid & T > cur_addr): ctrl_ena <= 0, remaining <= T - cur_addr, go to INC_HI.
  - Full case (otherwise, i.e. !sel_valid or T < cur_addr): ctrl_ena <= 0, remaining <= T, sel_valid <= 0, go to RST_LO.
- RST_LO: ctrl_sel_rst_n = 0 for PHASE cycles. Then go to RST_HI.
- RST_HI: ctrl_sel_rst_n = 1 for PHASE cycles. Then:
  - if remaining == 0, go to finish;
  - otherwise go to INC_HI.
- INC_HI: ctrl_sel_inc = 1 for PHASE cycles, then go to INC_LO.
- INC_LO: ctrl_sel_inc = 0 for PHASE cycles. Then decrement remaining; if the result is 0, go to finish, else go to INC_HI.
- Finish (on the edge ending the last phase): ctrl_ena <= captured req_ena, cur_addr <= T, sel_valid <= 1, state <= IDLE.
- Busy duration (cycles with req_ready = 0, counted from the accept edge):
  - full case: 2·PHASE·(1+T);
  - incremental case: 2·PHASE·(T − cur_addr).
- ctrl_ena is 0 throughout any non-IDLE state. It never glitches high during pulses.
- ctrl_sel_rst_n and ctrl_sel_inc are never both active in the same cycle.
- Arithmetic: unsigned, ADDR_W bits. T = 2^ADDR_W − 1 is legal; there is no wrap, and the maximum remaining count is 2^ADDR_W − 1.
- req_valid while busy is ignored (not queued). req_addr and req_ena changes while busy have no effect.
- rst mid-sequence: all outputs return to reset values immediately and sel_valid = 0. The next request therefore always takes the full path.

Test Plan:
- PHASE=2, after reset, req addr=3 ena=1: rst_n low 2 cycles, high 2, then 3 inc pulses of 2 hi/2 lo; req_ready low exactly 16 cycles; then ctrl_ena=1, cur_addr=3, sel_valid=1.
- Following req addr=5 ena=1: no rst_n pulse; ctrl_ena drops next cycle; exactly 2 inc pulses; busy 8 cycles; ctrl_ena=1, cur_addr=5.
- Following req addr=5 ena=0: req_ready never drops, no pulses, ctrl_ena=0 one cycle after accept edge.
- Following req addr=2 ena=1: full path, rst_n pulse plus 2 inc pulses, busy 12 cycles, cur_addr=2. Also after reset, req addr=0: rst pulse only, zero inc pulses, busy 4 cycles.
- Assert rst during 2nd inc pulse of an addr=7 request: same-cycle outputs rst_n=1, inc=0, ena=0, sel_valid=0. A subsequent req addr=1 takes the full path (busy 8 cycles).
- PHASE=1, ADDR_W=4, req addr=15: 15 inc pulses, busy 32 cycles, cur_addr=15. Scoreboard counts rising edges of ctrl_sel_inc equal to the delta for 200 random requests.

Source files
------------

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: converts a requested design address into the select-chain
// pulse train (optional chain reset, N increment pulses, enable update)
// and tracks which address the mux tree currently has selected.
module tt_sel_seq #(
  parameter int ADDR_W = 10,
  parameter int PHASE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              sel_valid,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int PW = $clog2(PHASE) + 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASE - 1);

  typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, INC_HI, INC_LO} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              ena_req_q, ena_req_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              valid_q, valid_d;
  logic              ena_q, ena_d;
  logic              rstn_q, rstn_d;
  logic              inc_q, inc_d;
  logic              accept;
  logic              phase_end;
  logic              finish;

  assign req_ready      = (state_q == IDLE);
  assign accept         = req_valid & req_ready;
  assign phase_end      = (phase_q == PH_LAST);
  assign sel_valid      = valid_q;
  assign cur_addr       = cur_q;
  assign ctrl_sel_rst_n = rstn_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;

  // Next-state, phase timing, increment bookkeeping and pin levels.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    tgt_d     = tgt_q;
    ena_req_d = ena_req_q;
    cur_d     = cur_q;
    valid_d   = valid_q;
    ena_d     = ena_q;
    finish    = 1'b0;

    // Phase counter only runs while sequencing; it wraps at every phase end
    // so it is back at zero whenever the block returns to IDLE.
    if (state_q != IDLE) begin
      phase_d = phase_end ? '0 : phase_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (valid_q && (req_addr == cur_q)) begin
            // Already selected: only the enable needs updating.
            ena_d = req_ena;
          end else begin
            ena_d     = 1'b0;
            tgt_d     = req_addr;
            ena_req_d = req_ena;
            phase_d   = '0;
            if (valid_q && (req_addr > cur_q)) begin
              // Chain can only count up, so forward moves skip the reset.
              rem_d   = req_addr - cur_q;
              state_d = INC_HI;
            end else begin
              rem_d   = req_addr;
              valid_d = 1'b0;
              state_d = RST_LO;
            end
          end
        end
      end
      RST_LO: begin
        if (phase_end) state_d = RST_HI;
      end
      RST_HI: begin
        if (phase_end) begin
          if (rem_q == '0) finish = 1'b1;
          else             state_d = INC_HI;
        end
      end
      INC_HI: begin
        if (phase_end) state_d = INC_LO;
      end
      INC_LO: begin
        if (phase_end) begin
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) finish = 1'b1;
          else                     state_d = INC_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      ena_d   = ena_req_q;
      cur_d   = tgt_q;
      valid_d = 1'b1;
    end

    // Pin levels follow the state being entered, so each pin phase lines up
    // exactly with its state's dwell time and the two pins never overlap.
    rstn_d = (state_d != RST_LO);
    inc_d  = (state_d == INC_HI);
  end

  // Control state and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      ena_q   <= 1'b0;
      rstn_q  <= 1'b1;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      ena_q   <= ena_d;
      rstn_q  <= rstn_d;
      inc_q   <= inc_d;
    end
  end

  // Captured request data; only consumed after an accept, so no reset.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    tgt_q     <= tgt_d;
    ena_req_q <= ena_req_d;
  end

endmodule

// File: tb/tb_tt_sel_seq.sv
// Bench for tt_sel_seq: two instances (PHASE=2/ADDR_W=10 and
// PHASE=1/ADDR_W=4) driven by directed requests; expected pulse counts,
// busy time and final selection are queued at accept and compared at finish.
module tb_tt_sel_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_req_valid, a_req_ena, a_req_ready, a_sel_valid;
  logic       a_rstn, a_inc, a_ena;
  logic [9:0] a_req_addr, a_cur_addr;
  logic       b_rst, b_req_valid, b_req_ena, b_req_ready, b_sel_valid;
  logic       b_rstn, b_inc, b_ena;
  logic [3:0] b_req_addr, b_cur_addr;

  tt_sel_seq #(.ADDR_W(10), .PHASE(2)) u_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr), .req_ena(a_req_ena), .sel_valid(a_sel_valid),
    .cur_addr(a_cur_addr), .ctrl_sel_rst_n(a_rstn), .ctrl_sel_inc(a_inc),
    .ctrl_ena(a_ena)
  );

  tt_sel_seq #(.ADDR_W(4), .PHASE(1)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_ena(b_req_ena), .sel_valid(b_sel_valid),
    .cur_addr(b_cur_addr), .ctrl_sel_rst_n(b_rstn), .ctrl_sel_inc(b_inc),
    .ctrl_ena(b_ena)
  );

  int          dsel = 0;
  logic        m_ready, m_valid, m_rstn, m_inc, m_ena;
  logic [31:0] m_cur;

  always_comb begin
    if (dsel == 0) begin
      m_ready = a_req_ready; m_valid = a_sel_valid; m_rstn = a_rstn;
      m_inc   = a_inc;       m_ena   = a_ena;       m_cur  = {22'b0, a_cur_addr};
    end else begin
      m_ready = b_req_ready; m_valid = b_sel_valid; m_rstn = b_rstn;
      m_inc   = b_inc;       m_ena   = b_ena;       m_cur  = {28'b0, b_cur_addr};
    end
  end

  typedef struct {
    int busy;
    int rstlo;
    int incs;
    int inchi;
    int cur;
    bit ena;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mcur[2];
  bit   mvalid[2];
  int   phs[2]   = '{2, 1};
  int   amax[2]  = '{1024, 16};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input int addr, input bit ena, input bit v);
    if (which == 0) begin
      a_req_valid = v; a_req_addr = 10'(addr); a_req_ena = ena;
    end else begin
      b_req_valid = v; b_req_addr = 4'(addr); b_req_ena = ena;
    end
  endtask

  task automatic set_rst(input int which, input bit v);
    if (which == 0) a_rst = v;
    else            b_rst = v;
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    set_rst(which, 1'b1);
    @(negedge clk);
    @(negedge clk);
    set_rst(which, 1'b0);
    mvalid[which] = 1'b0;
    mcur[which]   = 0;
  endtask

  // Issue one request; abort_at>0 asserts rst during that increment pulse,
  // noise drives a conflicting request while the block is busy.
  task automatic request(input int which, input int addr, input bit ena,
                         input int abort_at, input bit noise);
    exp_t e;
    exp_t got;
    int   p, d, lim, busy, rstlo, incs, inchi, viol;
    bit   done, aborted;
    logic prev_inc;
    p    = phs[which];
    dsel = which;
    @(negedge clk);
    if (mvalid[which] && addr == mcur[which]) begin
      e = '{0, 0, 0, 0, addr, ena};
    end else if (mvalid[which] && addr > mcur[which]) begin
      d = addr - mcur[which];
      e = '{2*p*d, 0, d, p*d, addr, ena};
    end else begin
      e = '{2*p*(1+addr), p, addr, p*addr, addr, ena};
    end
    sbq.push_back(e);
    check("ready_before_accept", m_ready, 1);
    drive(which, addr, ena, 1'b1);
    @(posedge clk);
    #1;
    drive(which, addr, ena, 1'b0);
    busy = 0; rstlo = 0; incs = 0; inchi = 0; viol = 0;
    prev_inc = 1'b0; done = 1'b0; aborted = 1'b0;
    lim = 2*p*(amax[which] + 1) + 20;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (m_ready) begin
        done = 1'b1;
        break;
      end
      busy++;
      if (!m_rstn) rstlo++;
      if (m_inc) inchi++;
      if (m_inc && !prev_inc) incs++;
      prev_inc = m_inc;
      if (m_ena || (!m_rstn && m_inc)) viol++;
      if (noise && busy == 3) drive(which, (addr + 5) % amax[which], !ena, 1'b1);
      if (abort_at > 0 && incs == abort_at && m_inc) begin
        aborted = 1'b1;
        break;
      end
    end
    drive(which, addr, ena, 1'b0);
    got = sbq.pop_front();
    if (aborted) begin
      #1 set_rst(which, 1'b1);
      #1;
      check("abort_rst_n", m_rstn, 1);
      check("abort_inc", m_inc, 0);
      check("abort_ena", m_ena, 0);
      check("abort_sel_valid", m_valid, 0);
      check("abort_cur_addr", m_cur, 0);
      @(negedge clk);
      set_rst(which, 1'b0);
      mvalid[which] = 1'b0;
      mcur[which]   = 0;
      return;
    end
    check("finish_in_budget", done, 1);
    check("busy_cycles", busy, got.busy);
    check("rst_n_low_cycles", rstlo, got.rstlo);
    check("inc_rising_edges", incs, got.incs);
    check("inc_high_cycles", inchi, got.inchi);
    check("pin_rules_violations", viol, 0);
    check("cur_addr", m_cur, got.cur);
    check("sel_valid", m_valid, 1);
    check("ctrl_ena", m_ena, got.ena);
    mvalid[which] = 1'b1;
    mcur[which]   = addr;
  endtask

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    drive(1, 0, 1'b0, 1'b0);
    #2;
    a_rst = 1'b1; b_rst = 1'b1;
    #1;
    // Reset values must appear before any clock edge.
    dsel = 0;
    #0;
    check("rst_a_rst_n", m_rstn, 1);
    check("rst_a_inc", m_inc, 0);
    check("rst_a_ena", m_ena, 0);
    check("rst_a_sel_valid", m_valid, 0);
    check("rst_a_cur_addr", m_cur, 0);
    dsel = 1;
    #1;
    check("rst_b_rst_n", m_rstn, 1);
    check("rst_b_sel_valid", m_valid, 0);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    mvalid[0] = 1'b0; mvalid[1] = 1'b0; mcur[0] = 0; mcur[1] = 0;
    dsel = 0;
    @(negedge clk);
    check("rst_a_ready", m_ready, 1);

    request(0, 3, 1'b1, 0, 1'b0);    // full path, busy 16
    request(0, 5, 1'b1, 0, 1'b1);    // incremental, busy 8, busy-time noise
    request(0, 5, 1'b0, 0, 1'b0);    // same address, no pulses
    request(0, 2, 1'b1, 0, 1'b0);    // backwards: full path, busy 12
    do_reset(0);
    request(0, 0, 1'b1, 0, 1'b0);    // reset pulse only, busy 4
    request(0, 7, 1'b1, 2, 1'b0);    // rst during second inc pulse
    request(0, 1, 1'b1, 0, 1'b0);    // must take full path, busy 8
    request(0, 1023, 1'b1, 0, 1'b0); // top address, incremental
    request(0, 1023, 1'b0, 0, 1'b0);

    request(1, 15, 1'b1, 0, 1'b0);   // PHASE=1: 15 pulses, busy 32
    for (int i = 0; i < 200; i++) begin
      request(1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
